uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
- Transmit sequencer for the UART transmitter.
- Accepts one byte at a time over a valid/ready handshake and latches the frame configuration: parity type, stop bits and data length.
- Builds the frame (start, 7/8 data bits LSB-first, optional parity, 1/2 stop bits; at most 12 bits) and times each bit with an internal baud counter.
- Drives the serial line; sits between the host-side byte source and the tx pin.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535; counter width is derived from it.

Ports:
clk  input  1  system clock; the block has one clock, all logic on its rising edge
rst  input  1  synchronous, active-high reset
tx_data  input  8  byte to send; bit 7 ignored when data_length=0
tx_valid  input  1  tx_data/config valid
tx_ready  output  1  block can accept a frame (registered)
parity_type  input  2  00 none, 01 even, 10 odd, 11 none
stop_bits  input  1  0: one stop bit, 1: two stop bits
data_length  input  1  0: 7 data bits, 1: 8 data bits
tx  output  1  serial line, idle high
busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse after last stop bit

Behaviour:
- Reset values: tx=1, tx_ready=1, busy=0, tx_done=0, state IDLE, counters 0.
- Reset has priority over every other event. Reset asserted mid-frame aborts the frame: tx=1 after that edge, frame not resumed, no tx_done.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, tx_ready=1.
  - Accept on an edge where tx_valid && tx_ready. At that edge latch tx_data, parity_type, stop_bits and data_length.
  - Compute parity from the valid data bits only: even = XOR of data bits; odd = its inverse.
  - Go to START with baud_cnt=0. tx_ready=0 and busy=1 from the next cycle.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
- DATA:
  - tx=data[bit_idx], LSB first, each bit for CLKS_PER_BIT cycles.
  - After bit 6 (data_length=0) or bit 7 (data_length=1): go to PARITY if parity enabled, else STOP.
- PARITY: tx=parity bit for CLKS_PER_BIT cycles, then STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles per stop bit (1 or 2).
  - On the last cycle of the last stop bit: go to IDLE; tx_done=1, tx_ready=1 and busy=0 for the following cycle.
- Bit advance: baud_cnt counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Every bit lasts exactly CLKS_PER_BIT cycles.
- Frame length in cycles = nbits*CLKS_PER_BIT, where nbits = 1 + (7|8) + (0|1) + (1|2), range 9..12.
- Back-to-back frames: a frame accepted in the tx_done cycle starts its start bit on the next cycle. The minimum line-idle gap between frames is therefore 1 cycle beyond the stop bits.
- Input changes while busy: tx_data and config changes are ignored. tx_valid is not accepted (tx_ready=0), and the source must hold tx_data/config until accepted.
- tx is driven from a register, so the line is glitch-free.

Test Plan:
All scenarios use CLKS_PER_BIT=4.
- 8N1: tx_data=0xA5, parity_type=00, stop_bits=0, data_length=1 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); tx_done pulses once on cycle 41; tx_ready=0 throughout the frame.
- 8E1 / 8O2: 0xAA with parity_type=01 -> parity bit 0, 11 bits. 0xF0 with parity_type=10, stop_bits=1 -> parity bit 1, two stop bits, 12 bits (48 cycles).
- 7E1: tx_data=0xD5, data_length=0, parity_type=01 -> data bits 1,0,1,0,1,0,1 (bit 7 ignored), parity 0, 10 bits (40 cycles).
- Mid-frame input churn: after accepting 0x3C, change tx_data to 0xFF, flip parity_type/stop_bits and pulse tx_valid during DATA -> serial output still 0x3C with the original config; second request not accepted until tx_ready returns.
- Reset mid-frame: assert rst for 1 cycle during DATA bit 3 -> tx=1, busy=0, tx_ready=1 after the reset edge; no tx_done; next frame 0x81 transmits correctly.
- Back-to-back: tx_valid held high with 0x11 then 0x22 -> second start bit begins exactly 1 cycle after the first frame's final stop-bit cycle; both frames bit-exact.

Source files
------------

// File: rtl/uart_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ctrl_if
// Description : Byte/config handshake plus serial-side status of the UART
//               transmit sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_ctrl_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [1:0] parity_type;
   logic       stop_bits;
   logic       data_length;
   logic       tx;
   logic       busy;
   logic       tx_done;

   modport master (
      output tx_data, tx_valid, parity_type, stop_bits, data_length,
      input  tx_ready, tx, busy, tx_done
   );

   modport slave (
      input  tx_data, tx_valid, parity_type, stop_bits, data_length,
      output tx_ready, tx, busy, tx_done
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ctrl
// Description : UART transmit sequencer: latches a byte and frame config,
//               then serialises start/data/parity/stop bits with a baud counter.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
   parameter int CLKS_PER_BIT = 16
) (
   input  wire              clk,
   input  wire              rst,
   uart_tx_ctrl_if.slave    bus
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   localparam logic [2:0] C_IDLE   = 3'd0;
   localparam logic [2:0] C_START  = 3'd1;
   localparam logic [2:0] C_DATA   = 3'd2;
   localparam logic [2:0] C_PARITY = 3'd3;
   localparam logic [2:0] C_STOP   = 3'd4;

   logic [2:0]       state_q,    state_d;
   logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]       bit_idx_q,  bit_idx_d;
   logic [7:0]       data_q,     data_d;
   logic             par_q,      par_d;
   logic             par_en_q,   par_en_d;
   logic             two_stop_q, two_stop_d;
   logic             len8_q,     len8_d;
   logic             stop_idx_q, stop_idx_d;
   logic             tx_q,       tx_d;
   logic             tx_ready_q, tx_ready_d;
   logic             busy_q,     busy_d;
   logic             tx_done_q,  tx_done_d;

   logic [7:0] w_masked_data;
   logic       w_par_even;
   logic       w_bit_end;
   logic [2:0] w_last_idx;
   logic [2:0] w_next_idx;

   // Parity covers only the bits that are actually sent.
   assign w_masked_data = bus.data_length ? bus.tx_data : {1'b0, bus.tx_data[6:0]};
   assign w_par_even    = ^w_masked_data;
   assign w_bit_end     = (baud_cnt_q == C_CNT_LAST);
   assign w_last_idx    = len8_q ? 3'd7 : 3'd6;
   assign w_next_idx    = bit_idx_q + 3'd1;

   // tx_d is the line level for the cycle after the edge, so tx stays registered.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_idx_d  = bit_idx_q;
      data_d     = data_q;
      par_d      = par_q;
      par_en_d   = par_en_q;
      two_stop_d = two_stop_q;
      len8_d     = len8_q;
      stop_idx_d = stop_idx_q;
      tx_d       = tx_q;
      tx_ready_d = tx_ready_q;
      busy_d     = busy_q;
      tx_done_d  = 1'b0;

      case (state_q)
         C_IDLE: begin
            tx_d       = 1'b1;
            tx_ready_d = 1'b1;
            busy_d     = 1'b0;
            if (bus.tx_valid && tx_ready_q) begin
               data_d     = bus.tx_data;
               par_d      = (bus.parity_type == 2'b10) ? ~w_par_even : w_par_even;
               par_en_d   = (bus.parity_type == 2'b01) || (bus.parity_type == 2'b10);
               two_stop_d = bus.stop_bits;
               len8_d     = bus.data_length;
               state_d    = C_START;
               baud_cnt_d = '0;
               tx_d       = 1'b0;
               tx_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         C_START: begin
            if (w_bit_end) begin
               baud_cnt_d = '0;
               bit_idx_d  = 3'd0;
               state_d    = C_DATA;
               tx_d       = data_q[0];
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
         C_DATA: begin
            if (w_bit_end) begin
               baud_cnt_d = '0;
               if (bit_idx_q == w_last_idx) begin
                  if (par_en_q) begin
                     state_d = C_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d    = C_STOP;
                     stop_idx_d = 1'b0;
                     tx_d       = 1'b1;
                  end
               end else begin
                  bit_idx_d = w_next_idx;
                  tx_d      = data_q[w_next_idx];
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
         C_PARITY: begin
            if (w_bit_end) begin
               baud_cnt_d = '0;
               state_d    = C_STOP;
               stop_idx_d = 1'b0;
               tx_d       = 1'b1;
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
         C_STOP: begin
            tx_d = 1'b1;
            if (w_bit_end) begin
               baud_cnt_d = '0;
               if (two_stop_q && !stop_idx_q) begin
                  stop_idx_d = 1'b1;
               end else begin
                  state_d    = C_IDLE;
                  tx_done_d  = 1'b1;
                  tx_ready_d = 1'b1;
                  busy_d     = 1'b0;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d    = C_IDLE;
            baud_cnt_d = '0;
            tx_d       = 1'b1;
            tx_ready_d = 1'b1;
            busy_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= C_IDLE;
         baud_cnt_q <= '0;
         bit_idx_q  <= 3'd0;
         data_q     <= 8'd0;
         par_q      <= 1'b0;
         par_en_q   <= 1'b0;
         two_stop_q <= 1'b0;
         len8_q     <= 1'b0;
         stop_idx_q <= 1'b0;
         tx_q       <= 1'b1;
         tx_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         data_q     <= data_d;
         par_q      <= par_d;
         par_en_q   <= par_en_d;
         two_stop_q <= two_stop_d;
         len8_q     <= len8_d;
         stop_idx_q <= stop_idx_d;
         tx_q       <= tx_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
         tx_done_q  <= tx_done_d;
      end
   end

   assign bus.tx       = tx_q;
   assign bus.tx_ready = tx_ready_q;
   assign bus.busy     = busy_q;
   assign bus.tx_done  = tx_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_ctrl
// Description : Self-checking bench: frame-level reference model plus
//               hand-written frame patterns for uart_tx_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;
   localparam int C = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   uart_tx_ctrl_if u_if ();

   uart_tx_ctrl #(.CLKS_PER_BIT(C)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   // Reference model: per-cycle expected {tx, busy, tx_ready, tx_done}.
   logic [3:0] exp_o = 4'b1010;
   logic [3:0] exp_q[$];
   bit         started = 0;

   task automatic build_frame(input logic [7:0] d, input logic [1:0] pt, input logic sb, input logic dl);
      logic bits[$];
      int   nd;
      logic p;
      nd = dl ? 8 : 7;
      p  = 1'b0;
      bits.push_back(1'b0);
      for (int i = 0; i < nd; i++) begin
         bits.push_back(d[i]);
         p = p ^ d[i];
      end
      if (pt == 2'b01) bits.push_back(p);
      if (pt == 2'b10) bits.push_back(~p);
      bits.push_back(1'b1);
      if (sb) bits.push_back(1'b1);
      foreach (bits[i])
         for (int k = 0; k < C; k++) exp_q.push_back({bits[i], 3'b100});
      exp_q.push_back(4'b1011);
   endtask

   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         exp_o   = 4'b1010;
         started = 1;
      end else begin
         if (exp_o[1] && u_if.tx_valid)
            build_frame(u_if.tx_data, u_if.parity_type, u_if.stop_bits, u_if.data_length);
         if (exp_q.size() > 0) exp_o = exp_q.pop_front();
         else                  exp_o = 4'b1010;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("model_tx",       u_if.tx,       exp_o[3]);
         chk("model_busy",     u_if.busy,     exp_o[2]);
         chk("model_tx_ready", u_if.tx_ready, exp_o[1]);
         chk("model_tx_done",  u_if.tx_done,  exp_o[0]);
      end
   end

   // mode 0: plain, 1: churn inputs mid-frame, 2: keep tx_valid with next byte nd
   task automatic send(input logic [7:0] d, input logic [1:0] pt, input logic sb,
                       input logic dl, input string lit, input int mode, input logic [7:0] nd);
      int cyc;
      int t;
      @(posedge clk); #2;
      u_if.tx_data     = d;
      u_if.parity_type = pt;
      u_if.stop_bits   = sb;
      u_if.data_length = dl;
      u_if.tx_valid    = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!u_if.tx_ready && t < 50);
      chk("accept_wait", (t < 50), 1);
      @(posedge clk); #2;
      if (mode == 2) u_if.tx_data  = nd;
      else           u_if.tx_valid = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk); cyc++;
         if (lit.len() > 0 && (cyc - 1) % C == 2 && (cyc - 1) / C < lit.len())
            chk("lit_bit", u_if.tx, (lit[(cyc - 1) / C] == "1"));
         if (mode == 1 && cyc == 10) begin
            u_if.tx_data     = 8'hFF;
            u_if.parity_type = ~pt;
            u_if.stop_bits   = ~sb;
            u_if.tx_valid    = 1'b1;
         end
         if (mode == 1 && cyc == 11) chk("churn_not_ready", u_if.tx_ready, 0);
         if (mode == 1 && cyc == 14) u_if.tx_valid = 1'b0;
      end while (!u_if.tx_done && cyc < 200);
      if (lit.len() > 0) chk("frame_len", cyc, lit.len() * C + 1);
      else               chk("done_seen", u_if.tx_done, 1);
      if (mode == 2) begin
         @(negedge clk);
         chk("b2b_start_tx",   u_if.tx,   0);
         chk("b2b_start_busy", u_if.busy, 1);
         u_if.tx_valid = 1'b0;
         t = 0;
         do begin @(negedge clk); t++; end while (!u_if.tx_done && t < 200);
         chk("b2b_second_len", t, 40);
      end
   endtask

   initial begin
      int  t;
      bit  done_seen;
      u_if.tx_data     = 8'h00;
      u_if.tx_valid    = 1'b0;
      u_if.parity_type = 2'b00;
      u_if.stop_bits   = 1'b0;
      u_if.data_length = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tx",       u_if.tx,       1);
      chk("rst_ready",    u_if.tx_ready, 1);
      chk("rst_busy",     u_if.busy,     0);
      chk("rst_done",     u_if.tx_done,  0);
      rst = 1'b0;

      send(8'hA5, 2'b00, 1'b0, 1'b1, "0101001011",   0, 8'h00);
      send(8'hAA, 2'b01, 1'b0, 1'b1, "00101010101",  0, 8'h00);
      send(8'hF0, 2'b10, 1'b1, 1'b1, "000001111111", 0, 8'h00);
      send(8'hD5, 2'b01, 1'b0, 1'b0, "0101010101",   0, 8'h00);
      send(8'h3C, 2'b00, 1'b0, 1'b1, "0001111001",   1, 8'h00);

      // Reset during data bit 3 of a frame.
      @(posedge clk); #2;
      u_if.tx_data     = 8'h5A;
      u_if.parity_type = 2'b01;
      u_if.stop_bits   = 1'b0;
      u_if.data_length = 1'b1;
      u_if.tx_valid    = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!u_if.tx_ready && t < 50);
      @(posedge clk); #2;
      u_if.tx_valid = 1'b0;
      repeat (18) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_tx",    u_if.tx,       1);
      chk("midrst_busy",  u_if.busy,     0);
      chk("midrst_ready", u_if.tx_ready, 1);
      done_seen = 0;
      repeat (60) begin
         @(negedge clk);
         if (u_if.tx_done) done_seen = 1;
      end
      chk("midrst_no_done", done_seen, 0);
      send(8'h81, 2'b00, 1'b0, 1'b1, "0100000011", 0, 8'h00);

      send(8'h11, 2'b00, 1'b0, 1'b1, "0100010001", 2, 8'h22);

      for (int i = 0; i < 30; i++) begin
         send(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), "", 0, 8'h00);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      repeat (5) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
`default_nettype wire
